// File: rtl/interval_timer.sv
// Countdown interval timer driven by an external 1 Hz tick enable, with one-shot/periodic mode.
// Latency: a start is visible on busy/remaining the edge it is accepted; expired follows the terminal tick by one edge.
// Backpressure: none; ticks are consumed or ignored each cycle, and pause only freezes the count.
module interval_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Hz1_enable,
    input  logic [WIDTH-1:0] value,
    input  logic             start_timer,
    input  logic             periodic,
    input  logic             pause,
    input  logic             abort,
    output logic             expired,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             divider_reset
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             start_q, start_d;
    logic             expired_q, expired_d;
    logic             div_rst_q, div_rst_d;

    logic             start_evt;
    logic             tick;
    logic             zero_interval;
    logic             last_tick;

    assign start_evt     = start_timer & ~start_q;
    assign tick          = Hz1_enable & ~pause & (state_q == RUN);
    assign zero_interval = (value == '0);
    assign last_tick     = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        start_d   = start_timer;
        expired_d = 1'b0;
        div_rst_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start_evt) begin
            div_rst_d = 1'b1;
            if (zero_interval) begin
                // A zero interval expires immediately and never arms a periodic reload.
                expired_d = 1'b1;
                state_d   = IDLE;
                count_d   = '0;
            end else begin
                state_d  = RUN;
                count_d  = value;
                reload_d = value;
                mode_d   = periodic;
            end
        end else if (tick) begin
            if (last_tick) begin
                expired_d = 1'b1;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            start_q   <= 1'b0;
            expired_q <= 1'b0;
            div_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            start_q   <= start_d;
            expired_q <= expired_d;
            div_rst_q <= div_rst_d;
        end
    end

    assign expired       = expired_q;
    assign busy          = (state_q == RUN);
    assign remaining     = count_q;
    assign divider_reset = div_rst_q;

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboarded bench: stimulus queues expected expired/divider_reset events, a monitor pops them.
module tb_interval_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         Reset;
    logic         Hz1_enable;
    logic [W-1:0] value;
    logic         start_timer;
    logic         periodic;
    logic         pause;
    logic         abort;
    logic         expired;
    logic         busy;
    logic [W-1:0] remaining;
    logic         divider_reset;

    interval_timer #(.WIDTH(W)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Hz1_enable   (Hz1_enable),
        .value        (value),
        .start_timer  (start_timer),
        .periodic     (periodic),
        .pause        (pause),
        .abort        (abort),
        .expired      (expired),
        .busy         (busy),
        .remaining    (remaining),
        .divider_reset(divider_reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         exp;
        logic         drst;
        logic         bsy;
        logic [W-1:0] rem;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Monitor: every cycle showing expired or divider_reset must match the next queued event.
    always @(negedge clk) begin
        ev_t act;
        ev_t want;
        act = '{exp: expired, drst: divider_reset, bsy: busy, rem: remaining};
        if (expired || divider_reset) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event t=%0t got exp=%0b drst=%0b busy=%0b rem=%0d, none expected",
                         $time, act.exp, act.drst, act.bsy, act.rem);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL event t=%0t got exp=%0b drst=%0b busy=%0b rem=%0d, want exp=%0b drst=%0b busy=%0b rem=%0d",
                             $time, act.exp, act.drst, act.bsy, act.rem,
                             want.exp, want.drst, want.bsy, want.rem);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, want);
        end
    endtask

    task automatic push(input logic e, input logic d, input logic b, input int r);
        ev_t ev;
        ev.exp  = e;
        ev.drst = d;
        ev.bsy  = b;
        ev.rem  = r[W-1:0];
        exp_q.push_back(ev);
    endtask

    // One tick, then one idle clock: tick period of 2 clocks.
    task automatic tick();
        Hz1_enable = 1'b1;
        cyc();
        Hz1_enable = 1'b0;
        cyc();
    endtask

    task automatic do_start(input int v, input logic per, input logic hz);
        if (v == 0) push(1'b1, 1'b1, 1'b0, 0);
        else        push(1'b0, 1'b1, 1'b1, v);
        value       = v[W-1:0];
        periodic    = per;
        start_timer = 1'b1;
        Hz1_enable  = hz;
        cyc();
        start_timer = 1'b0;
        Hz1_enable  = 1'b0;
        cyc();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rem", remaining, 0);
    endtask

    initial begin
        Reset = 1'b1; Hz1_enable = 1'b0; value = '0; start_timer = 1'b0;
        periodic = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (3) cyc();
        check("rst_expired", expired, 0);
        check("rst_busy", busy, 0);
        check("rst_rem", remaining, 0);
        check("rst_drst", divider_reset, 0);
        Reset = 1'b0;
        cyc();

        // One-shot interval of 6.
        do_start(6, 1'b0, 1'b0);
        check("os_rem_start", remaining, 6);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("os_rem", remaining, 6 - k);
        end
        push(1'b1, 1'b0, 1'b0, 0);
        tick();
        check("os_busy_end", busy, 0);
        check("os_rem_end", remaining, 0);

        // Periodic interval of 3; a mid-run change of value must not alter the period.
        do_start(3, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k % 3 == 0) push(1'b1, 1'b0, 1'b1, 3);
            tick();
            if (k == 2) value = 5;
            check("per_rem", remaining, (k % 3 == 0) ? 3 : 3 - (k % 3));
            check("per_busy", busy, 1);
        end
        do_abort();

        // Restart at remaining 4 with a new interval of 2.
        do_start(6, 1'b0, 1'b0);
        tick();
        tick();
        check("rs_rem4", remaining, 4);
        do_start(2, 1'b0, 1'b0);
        tick();
        check("rs_rem1", remaining, 1);
        push(1'b1, 1'b0, 1'b0, 0);
        tick();
        check("rs_busy_end", busy, 0);

        // Zero interval expires at once and leaves the timer idle.
        do_start(0, 1'b1, 1'b0);
        check("zero_busy", busy, 0);
        check("zero_rem", remaining, 0);

        // Pause holds the count at 3 for four ticks.
        do_start(5, 1'b0, 1'b0);
        tick();
        tick();
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("pause_rem", remaining, 3);
            check("pause_busy", busy, 1);
        end
        pause = 1'b0;
        tick();
        check("resume_rem", remaining, 2);
        tick();
        push(1'b1, 1'b0, 1'b0, 0);
        tick();
        check("resume_end", remaining, 0);

        // Start while paused loads normally.
        pause = 1'b1;
        do_start(3, 1'b0, 1'b0);
        tick();
        check("pstart_rem", remaining, 3);
        pause = 1'b0;
        tick();
        check("pstart_resume", remaining, 2);
        do_abort();

        // Start coincident with a tick loads value undecremented.
        do_start(4, 1'b0, 1'b1);
        check("st_tick_rem", remaining, 4);

        // Abort together with a start: the start is discarded.
        abort = 1'b1; start_timer = 1'b1; value = 7;
        cyc();
        abort = 1'b0;
        cyc();
        start_timer = 1'b0;
        check("ab_st_busy", busy, 0);
        check("ab_st_rem", remaining, 0);
        cyc();

        // Reset mid-run at remaining 2, with start held high across release.
        do_start(4, 1'b0, 1'b0);
        tick();
        tick();
        check("mr_rem2", remaining, 2);
        Reset = 1'b1; start_timer = 1'b1; value = 5; Hz1_enable = 1'b1;
        cyc();
        Hz1_enable = 1'b0;
        check("mr_outs", {expired, busy, remaining, divider_reset}, 0);
        cyc();
        push(1'b0, 1'b1, 1'b1, 5);
        Reset = 1'b0;
        cyc();
        check("mr_held_rem", remaining, 5);
        repeat (4) cyc();
        start_timer = 1'b0;
        check("mr_held_busy", busy, 1);
        do_abort();

        repeat (4) cyc();
        check("events_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "timeout");
    end

endmodule
